// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: digit count and the hex glyph table.
// Glyph bit order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    // Entry i holds the pattern that displays hex digit i.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of a seven-segment pattern into its hex nibble.
// match is low when the pattern is not one of the sixteen hex glyphs.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       match
);

    always_comb begin
        nibble = '0;
        match  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPH_TABLE[i]) begin
                nibble = 4'(i);
                match  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the four hex digits shown on a multiplexed seven-segment display by
// watching its segment and anode lines, publishing only complete, error-free frames.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        digit_err,
    output logic        frame_err
);

    logic [3:0]                  an_q;
    logic [6:0]                  seg_q;
    logic [10:0]                 prev_q;
    logic [7:0]                  cnt_q;
    logic [NUM_DIGITS-1:0][3:0]  digits_q;
    logic [NUM_DIGITS-1:0]       seen_q;
    logic [NUM_DIGITS-1:0]       bad_q;

    logic       same;
    logic       capture;
    logic       complete;
    logic       match;
    logic [3:0] nibble;
    logic [1:0] slot;

    // Capture fires on the edge the counter steps onto STABLE_CYCLES-1, so once per dwell.
    assign same     = ({an_q, seg_q} == prev_q);
    assign capture  = same && (cnt_q == 8'(STABLE_CYCLES - 2)) && $onehot(an_q);
    assign complete = &seen_q;

    always_comb begin
        slot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_q[i]) begin
                slot = 2'(i);
            end
        end
    end

    seg7_pattern_decode u_decode (
        .pattern (seg_q),
        .nibble  (nibble),
        .match   (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q   <= '0;
            seg_q  <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            an_q   <= an;
            seg_q  <= seg;
            prev_q <= {an_q, seg_q};
            if (!same) begin
                cnt_q <= '0;
            end else if (cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // A completed frame is consumed before any further capture can land.
    always_ff @(posedge clk) begin
        if (rst) begin
            value       <= '0;
            value_valid <= 1'b0;
            digit_err   <= 1'b0;
            frame_err   <= 1'b0;
            digits_q    <= '0;
            seen_q      <= '0;
            bad_q       <= '0;
        end else begin
            value_valid <= 1'b0;
            digit_err   <= 1'b0;
            frame_err   <= 1'b0;
            if (complete) begin
                if (bad_q == '0) begin
                    value       <= digits_q;
                    value_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
                seen_q <= '0;
                bad_q  <= '0;
            end else if (capture) begin
                digits_q[slot] <= nibble;
                seen_q[slot]   <= 1'b1;
                bad_q[slot]    <= !match;
                digit_err      <= !match;
            end
        end
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4 (legal 2..255), is the number of consecutive identical samples required before a digit is captured.
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, synchronous, active-high reset.
REQ-004 Port seg, input, 7, segment pattern {a,b,c,d,e,f,g}, active-high.
REQ-005 Port an, input, 4, digit select, active-high, one-hot; an[i] selects digit i.
REQ-006 Port value, output, 16, last good decoded frame; digit i is in value[4i+3:4i].
REQ-007 Port value_valid, output, 1, one-cycle pulse: value updated this cycle.
REQ-008 Port digit_err, output, 1, one-cycle pulse: a captured pattern matched no hex glyph.
REQ-009 Port frame_err, output, 1, one-cycle pulse: a frame completed containing at least one bad digit.

Function
REQ-010 The block shall register seg and an once before any other logic; all behaviour is defined on the registered sample.
REQ-011 Glyph table (hex:pattern) shall be: 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000, 8:1111111, 9:1111011, A:1110111, B:0011111, C:1001110, D:0111101, E:1001111, F:1000111.
REQ-012 Stability counter: increments, saturating, while the sample {an,seg} equals the previous sample; clears to 0 on any difference.
REQ-013 A digit shall be captured exactly once per dwell, when the counter reaches STABLE_CYCLES-1 and an is one-hot.
REQ-014 Inputs held constant from edge N shall be captured at edge N+STABLE_CYCLES.
REQ-015 A non-one-hot an (0000 or multiple bits) shall be treated as blanking: no capture, no error, and the counter shall still track it.
REQ-016 On capture, the decoded nibble shall be stored in digit slot i, the slot's seen bit set, and its bad bit set or cleared according to glyph match.
REQ-017 An unmatched pattern at capture shall pulse digit_err on the cycle after capture.
REQ-018 A re-capture of an already-seen slot before frame completion shall overwrite the nibble and bad bit.
REQ-019 When all four seen bits are set with no bad bits, value shall load all four nibbles and value_valid shall pulse on the following edge.
REQ-020 When all four seen bits are set with any bad bit, value shall be held and frame_err shall pulse on the following edge.
REQ-021 After either completion outcome, the seen and bad masks shall clear in the same cycle.
REQ-022 Completion and a new capture cannot occur in the same cycle (STABLE_CYCLES>=2); no arbitration is required.

Reset
REQ-023 While rst=1 at a clock edge: value=16'h0000, all pulses 0, counter 0, seen/bad masks 0, sample registers 0.
REQ-024 Reset mid-frame shall discard partial digits; a full frame is required afterwards before value_valid.
REQ-025 The first capture after reset shall need a full STABLE_CYCLES dwell from the first post-reset sample.

Structure
REQ-026 Package seg7_pkg shall hold the 16 glyph constants and the digit-count constant (4).
REQ-027 Sub-module seg7_pattern_decode (combinational: 7-bit pattern -> 4-bit nibble + match flag) shall be instantiated once.
REQ-028 All other logic (sample register, counter, masks, frame assembly) shall reside in seg7_scan_decoder.

Verification
REQ-029 Good frame test:
- Stimulus: STABLE_CYCLES=4; hold an=0001/seg=1011011, an=0010/1110111, an=0100/1111001, an=1000/1001111 for 6 cycles each.
- Required response: value=16'hE3A5 with exactly one value_valid pulse.
REQ-030 Glitch rejection test:
- Stimulus: a 3-cycle dwell, then any change.
- Required response: no capture; value and all pulses unchanged.
REQ-031 Bad glyph test:
- Stimulus: good frame, but digit 2 carries seg=0000001.
- Required response: one digit_err pulse and one frame_err pulse; value retains the prior frame; no value_valid.
REQ-032 Blanking and overwrite test:
- Stimulus: an=0000 for 10 cycles between digits; digit 0 dwelt twice (5 then 7) before the frame completes.
- Required response: no errors; the final value carries 7 in nibble 0.
REQ-033 Reset test:
- Stimulus: rst asserted after 2 digits are captured, then a full frame of 16'h1234.
- Required response: value=0 during reset; next value_valid shows 16'h1234.
REQ-034 Latency test:
- Stimulus: constant input from edge N.
- Required response: capture at N+4; value_valid at N+5 for the completing digit.
